// File: rtl/asym_fifo_pkg.sv
// Shared constants and types for the asymmetric FIFO controller.
// A write stores one double-width word as two consecutive entries; a read
// pops one single-width entry, so the two pointers advance at different rates.
package asym_fifo_pkg;

    // Default storage address width; modules may override it with their own parameter.
    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    // Entries consumed per accepted write / read.
    localparam int WR_STEP = 2;
    localparam int RD_STEP = 1;

    // One extra MSB on the pointers tells a full FIFO from an empty one.
    typedef logic [ADDR_WIDTH:0]   ptr_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : asym_fifo_pkg

// File: rtl/asym_fifo_ctrl.sv
// Pointer and flag controller for the asymmetric FIFO.
// Drives the register-file storage's w_en / w_addr / r_addr and reports
// occupancy, full and empty. All outputs are combinational from the two
// pointer registers and the request inputs.
// Optional feature: define ASYM_FIFO_ERR_EN to add a sticky 'err' output that
// flags any write attempted while full or read attempted while empty.
module asym_fifo_ctrl
    import asym_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = asym_fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   occupancy
`ifdef ASYM_FIFO_ERR_EN
    ,
    output logic                  err
`endif
);

    // Local pointer type follows the module parameter, not the package default.
    typedef logic [ADDR_WIDTH:0] ctrl_ptr_t;

    // Full as soon as fewer than two entries are free: a write needs two.
    localparam ctrl_ptr_t FULL_LIMIT = ctrl_ptr_t'((2 ** ADDR_WIDTH) - 2);
    localparam ctrl_ptr_t WR_INC     = ctrl_ptr_t'(WR_STEP);
    localparam ctrl_ptr_t RD_INC     = ctrl_ptr_t'(RD_STEP);

    ctrl_ptr_t wptr;
    ctrl_ptr_t rptr;
    logic      wr_ok;
    logic      rd_ok;

    // Flags and addresses straight from the pointers; modular subtraction
    // handles wrap-around because both pointers carry the extra MSB.
    assign occupancy = wptr - rptr;
    assign empty     = (occupancy == '0);
    assign full      = (occupancy > FULL_LIMIT);
    assign w_addr    = wptr[ADDR_WIDTH-1:0];
    assign r_addr    = rptr[ADDR_WIDTH-1:0];

    // Each request is judged against this cycle's flags only; a same-cycle
    // read does not make room for a write, nor a write supply a read.
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;
    assign w_en  = wr_ok;

    // Write pointer: advances by one double-width word (two entries).
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            wptr <= '0;
        end else if (wr_ok) begin
            wptr <= wptr + WR_INC;
        end
    end

    // Read pointer: advances by one entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr <= '0;
        end else if (rd_ok) begin
            rptr <= rptr + RD_INC;
        end
    end

`ifdef ASYM_FIFO_ERR_EN
    // Sticky error: set by any rejected request, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((wr & full) | (rd & empty)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule : asym_fifo_ctrl
